round_sequencer: RTL

- Game controller for the finger-pattern game; it sequences every round.
- Owns the round countdown, pattern generation, input judging, score and game-over state.
- Sits between the 1 Hz tick generator and debounced start button on the input side, and the display block on the output side.
- Replaces the free-running round counter, the separate pattern/score/input registers and the game-state flop with a single FSM.

---
 rtl/round_sequencer_if.sv | 24 ++
 rtl/round_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/round_sequencer_if.sv
// Player-side and display-side signals of the round sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface round_sequencer_if;
   logic       tick;
   logic       start;
   logic [3:0] sw;
   logic [3:0] pattern;
   logic [7:0] score;
   logic [3:0] time_left;
   logic       round_res;
   logic       round_done;
   logic       game_active;
   logic       game_over;

   modport slave (
      input  tick, start, sw,
      output pattern, score, time_left, round_res, round_done, game_active, game_over
   );

   modport master (
      output tick, start, sw,
      input  pattern, score, time_left, round_res, round_done, game_active, game_over
   );
endinterface

// File: rtl/round_sequencer.sv
// Finger-pattern game controller: round countdown, pattern generation, judging, score, game over.
// Optional EARLY_MATCH_EN: judge as soon as the synchronized switches match the pattern.
module round_sequencer #(
   parameter int         ROUND_TICKS   = 10,
   parameter int         MIN_TICKS     = 3,
   parameter int         SPEEDUP_EVERY = 4,
   parameter int         MAX_SCORE     = 99,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input logic               clk,
   input logic               rst_n,
   round_sequencer_if.slave  bus
);

   localparam logic [3:0] RT  = 4'(ROUND_TICKS);
   localparam logic [3:0] MT  = 4'(MIN_TICKS);
   localparam logic [3:0] SE  = 4'(SPEEDUP_EVERY);
   localparam logic [7:0] MXS = 8'(MAX_SCORE);

   typedef enum logic [2:0] {IDLE, ARM, PLAY, JUDGE, OVER} state_t;

   state_t          state, state_nx;
   logic [7:0]      lfsr;
   logic [1:0][3:0] sw_sync;
   logic [3:0]      sw_s;
   logic            start_q;
   logic            start_rise;

   logic [3:0] pattern_q, pattern_nx;
   logic [7:0] score_q, score_nx;
   logic [3:0] time_q, time_nx;
   logic       res_q, res_nx;
   logic       done_q, done_nx;
   logic       active_q, active_nx;
   logic       over_q, over_nx;
   logic [3:0] streak, streak_nx;
   logic [3:0] round_len, len_nx;
   logic [3:0] judge_in, judge_nx;
   logic       hit;

   assign sw_s       = sw_sync[1];
   assign start_rise = bus.start & ~start_q;
   assign hit        = (judge_in == pattern_q);

   // Never zero and never a repeat of the previous pattern.
   function automatic logic [3:0] next_pat(input logic [3:0] rnd, input logic [3:0] cur);
      logic [3:0] c;
      c = (rnd == 4'h0) ? 4'h1 : rnd;
      if (c == cur)
         c = (cur == 4'hF) ? 4'h1 : cur + 4'h1;
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         lfsr      <= LFSR_SEED;
         sw_sync   <= '0;
         start_q   <= 1'b0;
         pattern_q <= '0;
         score_q   <= '0;
         time_q    <= '0;
         res_q     <= 1'b0;
         done_q    <= 1'b0;
         active_q  <= 1'b0;
         over_q    <= 1'b0;
         streak    <= '0;
         round_len <= RT;
         judge_in  <= '0;
      end else begin
         state     <= state_nx;
         // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
         lfsr      <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
         sw_sync   <= {sw_sync[0], bus.sw};
         start_q   <= bus.start;
         pattern_q <= pattern_nx;
         score_q   <= score_nx;
         time_q    <= time_nx;
         res_q     <= res_nx;
         done_q    <= done_nx;
         active_q  <= active_nx;
         over_q    <= over_nx;
         streak    <= streak_nx;
         round_len <= len_nx;
         judge_in  <= judge_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      pattern_nx = pattern_q;
      score_nx   = score_q;
      time_nx    = time_q;
      res_nx     = res_q;
      done_nx    = 1'b0;
      streak_nx  = streak;
      len_nx     = round_len;
      judge_nx   = judge_in;

      case (state)
         IDLE: begin
            if (start_rise)
               state_nx = ARM;
         end
         ARM: begin
            score_nx   = '0;
            streak_nx  = '0;
            len_nx     = RT;
            pattern_nx = next_pat(lfsr[3:0], pattern_q);
            time_nx    = RT;
            res_nx     = 1'b0;
            state_nx   = PLAY;
         end
         PLAY: begin
`ifdef EARLY_MATCH_EN
            if (sw_s == pattern_q) begin
               judge_nx = sw_s;
               state_nx = JUDGE;
            end else
`endif
            if (bus.tick) begin
               if (time_q == 4'd1) begin
                  judge_nx = sw_s;
                  state_nx = JUDGE;
               end else begin
                  time_nx = time_q - 4'd1;
               end
            end
         end
         JUDGE: begin
            done_nx = 1'b1;
            res_nx  = hit;
            if (hit) begin
               if (score_q < MXS)
                  score_nx = score_q + 8'd1;
               if (streak + 4'd1 == SE) begin
                  streak_nx = '0;
                  if (round_len > MT)
                     len_nx = round_len - 4'd1;
               end else begin
                  streak_nx = streak + 4'd1;
               end
               pattern_nx = next_pat(lfsr[3:0], pattern_q);
               time_nx    = len_nx;
               state_nx   = PLAY;
            end else begin
               time_nx  = '0;
               state_nx = OVER;
            end
         end
         OVER: begin
            if (start_rise)
               state_nx = ARM;
         end
         default: state_nx = IDLE;
      endcase

      active_nx = (state_nx == PLAY) || (state_nx == JUDGE);
      over_nx   = (state_nx == OVER);
   end

   assign bus.pattern     = pattern_q;
   assign bus.score       = score_q;
   assign bus.time_left   = time_q;
   assign bus.round_res   = res_q;
   assign bus.round_done  = done_q;
   assign bus.game_active = active_q;
   assign bus.game_over   = over_q;

endmodule
